// File: rtl/cpu_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Stats counters exist only when HAZARD_STATS_EN is defined.
package cpu_pkg;

    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned MULDIV_CNT_W = 4;
    localparam int unsigned STAT_W       = 32;

    typedef enum logic {
        StIdle,
        StBusy
    } hazard_state_e;

    // Saturating increment: the counter sticks at all-ones rather than wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] val,
                                                  input logic              en);
        if (en && (val != {STAT_W{1'b1}})) begin
            return val + 1'b1;
        end
        return val;
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Multi-cycle mult/div occupancy sequencer for EX: an IDLE/BUSY FSM with a down-counter.
// It holds EX for MULDIV_LAT-1 cycles and flags the result in the final cycle.
module muldiv_seq
    import cpu_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    output logic hold_o,
    output logic done_o,
    output logic busy_o
);

    // The start cycle counts as one hold cycle, so the counter is loaded with two less
    // than the latency.
    localparam logic [MULDIV_CNT_W-1:0] CntInit = MULDIV_CNT_W'(MULDIV_LAT - 2);

    hazard_state_e             state_q;
    logic [MULDIV_CNT_W-1:0]   cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StBusy;
                        cnt_q   <= CntInit;
                    end
                end
                StBusy: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign busy_o = (state_q == StBusy);
    assign hold_o = ((state_q == StIdle) && start_i) || ((state_q == StBusy) && (cnt_q != '0));
    assign done_o = (state_q == StBusy) && (cnt_q == '0);

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use detection, mult/div EX occupancy
// and taken-branch squash. Define HAZARD_STATS_EN to add saturating event counters.
module hazard_unit
#(
    parameter int unsigned MULDIV_LAT = 4,
    parameter int unsigned REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs_id,
    input  logic [REG_ADDR_W-1:0] rt_id,
    input  logic                  uses_rs_id,
    input  logic                  uses_rt_id,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic                  RegWrite_ex,
    input  logic                  MemRead_ex,
    input  logic                  muldiv_start_ex,
    input  logic                  branch_taken_ex,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  bubble_ex,
    output logic                  flush_id,
    output logic                  hold_ex,
    output logic                  muldiv_busy,
`ifdef HAZARD_STATS_EN
    output logic [31:0]           stat_lu_stalls,
    output logic [31:0]           stat_muldiv_cycles,
    output logic [31:0]           stat_flushes,
`endif
    output logic                  muldiv_done
);

    import cpu_pkg::*;

    logic seq_hold;
    logic lu_hit;
    logic lu_stall;

    muldiv_seq #(
        .MULDIV_LAT (MULDIV_LAT)
    ) u_muldiv_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (muldiv_start_ex),
        .hold_o  (seq_hold),
        .done_o  (muldiv_done),
        .busy_o  (muldiv_busy)
    );

    // r0 is hardwired zero, so a load targeting it never produces a real dependency.
    assign lu_hit = MemRead_ex && RegWrite_ex && (rd_ex != '0) &&
                    ((uses_rs_id && (rd_ex == rs_id)) || (uses_rt_id && (rd_ex == rt_id)));

    assign lu_stall = lu_hit && !seq_hold && !branch_taken_ex;

    always_comb begin
        hold_ex   = seq_hold;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        bubble_ex = 1'b0;
        flush_id  = 1'b0;
        if (seq_hold) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
        end else if (branch_taken_ex) begin
            // The ID instruction is wrong-path, so any hazard it carries is moot.
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
        end else if (lu_hit) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] lu_cnt_q;
    logic [STAT_W-1:0] md_cnt_q;
    logic [STAT_W-1:0] fl_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt_q <= '0;
            md_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else begin
            lu_cnt_q <= sat_inc(lu_cnt_q, lu_stall);
            md_cnt_q <= sat_inc(md_cnt_q, hold_ex);
            fl_cnt_q <= sat_inc(fl_cnt_q, flush_id);
        end
    end

    assign stat_lu_stalls     = lu_cnt_q;
    assign stat_muldiv_cycles = md_cnt_q;
    assign stat_flushes       = fl_cnt_q;
`else
    logic unused_lu_stall;
    assign unused_lu_stall = lu_stall;
`endif

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage MIPS core: the stall/flush side of the operand-bypass scheme. It detects load-use hazards the bypass network cannot resolve, sequences multi-cycle multiply/divide occupancy of EX, and squashes wrong-path instructions on taken branches. It sits beside the ID/EX boundary and drives the PC, IF/ID and ID/EX pipeline-register enables.

## Interface
- MULDIV_LAT, 4, total EX cycles a mult/div instruction occupies; legal range 2..15
- REG_ADDR_W, 5, register address width

- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- rs_id, rt_id  in  REG_ADDR_W each  source registers of the instruction in ID
- uses_rs_id, uses_rt_id  in  1 each  ID instruction actually reads rs / rt
- rd_ex  in  REG_ADDR_W  destination of the instruction in EX
- RegWrite_ex, MemRead_ex  in  1 each  EX instruction writes a register / is a load
- muldiv_start_ex  in  1  EX instruction is a multi-cycle mult/div; sampled only in IDLE
- branch_taken_ex  in  1  branch/jump in EX resolved taken
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- bubble_ex  out  1  load a NOP into ID/EX
- flush_id  out  1  replace IF/ID contents with NOP
- hold_ex  out  1  freeze ID/EX and EX-internal state; EX/MEM receives a NOP
- muldiv_busy  out  1  FSM in BUSY
- muldiv_done  out  1  mult/div result valid in EX this cycle

## Operation
- Outputs combinational from FSM state, counter and inputs; only FSM state, 4-bit counter (and stats counters) are registered.
- FSM states: IDLE, BUSY.
  - IDLE, muldiv_start_ex=1: hold_ex=1; cnt <= MULDIV_LAT-2; go BUSY.
  - BUSY, cnt!=0: hold_ex=1; cnt <= cnt-1.
  - BUSY, cnt==0: hold_ex=0, muldiv_done=1; go IDLE.
  - muldiv_start_ex ignored in BUSY (same instruction still in EX).
- Whenever hold_ex=1: stall_if=stall_id=1, bubble_ex=0, flush_id=0.
- Load-use (hold_ex=0): lu = MemRead_ex & RegWrite_ex & (rd_ex!=0) & ((uses_rs_id & rd_ex==rs_id) | (uses_rt_id & rd_ex==rt_id)). lu -> stall_if=stall_id=bubble_ex=1.
- Branch (hold_ex=0): branch_taken_ex -> flush_id=1, bubble_ex=1, stall_if=stall_id=0; overrides lu (ID instruction is wrong-path).
- Priority: hold_ex > branch flush > load-use > none.
- Register 0 never causes a stall; unused source fields never cause a stall.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, cnt 0, stats 0; with inputs low all outputs 0. Reset mid-BUSY aborts the sequence immediately; first cycle after release is IDLE.
- Load-use stall: exactly one cycle; next cycle the load is in MEM and bypass resolves the operand.
- Mult/div started in cycle T: hold_ex high T..T+MULDIV_LAT-2, muldiv_done high at T+MULDIV_LAT-1, instruction leaves EX at the following edge. muldiv_busy high T+1..T+MULDIV_LAT-1.
- Back-to-back mult/div: second instruction enters EX at T+MULDIV_LAT, seen in IDLE, starts a fresh sequence with no gap cycle.
- branch_taken_ex and muldiv_start_ex cannot coincide (decoder guarantee); if both assert, muldiv wins.

## Configuration
- HAZARD_STATS_EN defined: adds outputs stat_lu_stalls, stat_muldiv_cycles, stat_flushes (32 bits each, saturating at all-ones), incremented on each cycle with a load-use stall, hold_ex=1, flush_id=1 respectively; reset to 0.
- Undefined: ports and counters absent; remaining behaviour identical.

## Structure
- cpu_pkg: REG_ADDR_W constant, hazard FSM state typedef (IDLE, BUSY), stats counter width.
- One sub-module: muldiv_seq (FSM + down-counter; outputs hold, done, busy). Load-use and flush priority logic stays in hazard_unit.

## Test plan
- Load r8 in EX (MemRead_ex=1, RegWrite_ex=1, rd_ex=8), ID reads rs=8 -> stall_if=stall_id=bubble_ex=1 for exactly one cycle; same with rd_ex=0 -> no stall.
- rd_ex=8 load, ID rt_id=8 with uses_rt_id=0 -> no stall.
- MULDIV_LAT=4, muldiv_start_ex at T -> hold_ex high T,T+1,T+2; muldiv_done at T+3; outputs 0 at T+4 with no new start.
- Load-use condition and branch_taken_ex together -> flush_id=1, bubble_ex=1, stall_if=0.
- rst_n pulsed low at T+1 of a mult/div sequence -> all outputs 0 during reset; IDLE after release, no muldiv_done.
- With HAZARD_STATS_EN: two load-use stalls, one MULDIV_LAT=4 op, one flush -> stats read 2, 3, 1.
